// File: rtl/axi4lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4lite_pkg
// Shared definitions for the AXI4-Lite command master:
//   state_t   - FSM state encoding used by axi4lite_master
//   RESP_OKAY - AXI "OKAY" response code (RRESP/BRESP = 0)
// -----------------------------------------------------------------------------
package axi4lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,  // waiting for a command, cmd_ready high
        WR      = 3'd1,  // AW and W channels in flight
        WR_RESP = 3'd2,  // waiting for the B channel
        RD_ADDR = 3'd3,  // AR channel in flight
        RD_DATA = 3'd4,  // waiting for the R channel
        RSP     = 3'd5   // one-cycle completion pulse towards the user
    } state_t;

    localparam int RESP_OKAY = 0;

endpackage

// File: rtl/axi4lite_intf.sv
// -----------------------------------------------------------------------------
// axi4lite_intf
// AXI4-Lite signal bundle (AW, W, B, AR, R channels).
// Modports:
//   slave  - samples AW*/W*/AR*/BREADY/RREADY, drives the ready/response side
//   master - the mirror image of slave
// -----------------------------------------------------------------------------
interface axi4lite_intf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 1
);
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;

    // Write address channel
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    // Write data channel
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    // Write response channel
    logic [RESP_WIDTH-1:0] BRESP;
    logic                  BVALID;
    logic                  BREADY;
    // Read address channel
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    // Read data channel
    logic [DATA_WIDTH-1:0] RDATA;
    logic [RESP_WIDTH-1:0] RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport slave (
        input  AWADDR, AWVALID,
        input  WDATA, WSTRB, WVALID,
        input  BREADY,
        input  ARADDR, ARVALID,
        input  RREADY,
        output AWREADY, WREADY,
        output BRESP, BVALID,
        output ARREADY,
        output RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWVALID,
        output WDATA, WSTRB, WVALID,
        output BREADY,
        output ARADDR, ARVALID,
        output RREADY,
        input  AWREADY, WREADY,
        input  BRESP, BVALID,
        input  ARREADY,
        input  RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/axi4lite_master.sv
// -----------------------------------------------------------------------------
// axi4lite_master
// Turns single user commands into AXI4-Lite read or write transactions, one
// at a time, and reports each completion with a one-cycle rsp_valid pulse.
//
// Ports:
//   ACLK, ARESETn      clock (rising edge) and asynchronous active-low reset
//   cmd_valid/ready    command handshake; cmd_ready is registered, high in IDLE
//   cmd_write          1 = write, 0 = read
//   cmd_addr/wdata/wstrb  command payload, captured on accept
//   rsp_valid          one-cycle completion pulse
//   rsp_write          completed command was a write
//   rsp_rdata          read data (0 for writes), held until the next completion
//   rsp_resp           raw BRESP/RRESP, passed through unmodified
//   bus                AXI4-Lite master modport
//
// Every bus VALID/READY is a flop cleared by the asynchronous reset, so a reset
// in the middle of a transaction drops them immediately.
// -----------------------------------------------------------------------------
module axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int RESP_WIDTH = 1,
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [RESP_WIDTH-1:0] rsp_resp,
    axi4lite_intf.master          bus
);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t                state_q,     state_d;
    logic                  cmd_ready_d;
    logic                  write_q,     write_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,     wstrb_d;
    logic                  awvalid_q,   awvalid_d;
    logic                  wvalid_q,    wvalid_d;
    logic                  aw_done_q,   aw_done_d;
    logic                  w_done_q,    w_done_d;
    logic                  bready_q,    bready_d;
    logic                  arvalid_q,   arvalid_d;
    logic                  rready_q,    rready_d;
    logic                  rsp_valid_d;
    logic                  rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic [RESP_WIDTH-1:0] rsp_resp_d;

    // Channel handshakes, qualified by our own registered VALID/READY.
    logic accept;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    assign accept = cmd_valid && cmd_ready;
    assign aw_hs  = awvalid_q && bus.AWREADY;
    assign w_hs   = wvalid_q  && bus.WREADY;
    assign b_hs   = bready_q  && bus.BVALID;
    assign ar_hs  = arvalid_q && bus.ARREADY;
    assign r_hs   = rready_q  && bus.RVALID;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first so that no path through
        // the case statement leaves one unassigned (which would infer a latch).
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write;
        rsp_rdata_d = rsp_rdata;
        rsp_resp_d  = rsp_resp;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        // AW and W are offered together; the slave may take
                        // them in any order.
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end

            WR: begin
                // Each channel retires on its own handshake; the done flags
                // remember which one already went through.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = WR_RESP;
                end
            end

            WR_RESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = write_q;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bus.BRESP;
                    state_d     = RSP;
                end
            end

            RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = write_q;
                    rsp_rdata_d = bus.RDATA;
                    rsp_resp_d  = bus.RRESP;
                    state_d     = RSP;
                end
            end

            RSP: begin
                // rsp_valid is high for exactly this one cycle.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered ready: high exactly while the FSM sits in IDLE, and never
        // a function of cmd_valid in the same cycle.
        cmd_ready_d = (state_d == IDLE);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            cmd_ready <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= cmd_ready_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rsp_valid <= rsp_valid_d;
            rsp_write <= rsp_write_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_resp  <= rsp_resp_d;
        end
    end

    // -------------------------------------------------------------------------
    // Bus drive: payload comes straight from the command registers, which only
    // change on accept, so it is stable for as long as any VALID is pending.
    // -------------------------------------------------------------------------
    assign bus.AWADDR  = addr_q;
    assign bus.AWVALID = awvalid_q;
    assign bus.WDATA   = wdata_q;
    assign bus.WSTRB   = wstrb_q;
    assign bus.WVALID  = wvalid_q;
    assign bus.BREADY  = bready_q;
    assign bus.ARADDR  = addr_q;
    assign bus.ARVALID = arvalid_q;
    assign bus.RREADY  = rready_q;

endmodule

// File: tb/tb_axi4lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_master
// Directed and randomized bench for axi4lite_master. A delay-programmable
// AXI4-Lite slave answers the master; a scoreboard predicts each completion
// (fields, latency from the per-channel slave delays) from the command alone.
// -----------------------------------------------------------------------------
module tb_axi4lite_master;
    import axi4lite_pkg::*;

    logic        ACLK;
    logic        ARESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [0:0]  rsp_resp;

    axi4lite_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_WIDTH(1)) bus ();

    axi4lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_WIDTH(1)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Slave configuration for the current transaction.
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [0:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    // What the slave saw.
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

    // Per-transaction waveform history, indexed by cycles since accept.
    logic awv_hist [64];
    logic wv_hist  [64];
    logic arv_hist [64];
    logic brdy_hist[64];
    bit   in_txn = 1'b0;
    int   t_acc  = 0;
    int   mon_rel;
    int   proto_err = 0;
    logic p_aw_pend, p_w_pend, p_ar_pend;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    // ---------------- slave: one process per channel, driving at negedge ----
    initial begin
        bus.AWREADY = 1'b0;
        aw_cnt = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn || bus.AWREADY) begin
                bus.AWREADY = 1'b0;
                aw_cnt = 0;
            end else if (bus.AWVALID) begin
                if (aw_cnt < aw_d) aw_cnt++;
                else begin
                    bus.AWREADY = 1'b1;
                    cap_awaddr  = bus.AWADDR;
                end
            end
        end
    end

    initial begin
        bus.WREADY = 1'b0;
        w_cnt = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn || bus.WREADY) begin
                bus.WREADY = 1'b0;
                w_cnt = 0;
            end else if (bus.WVALID) begin
                if (w_cnt < w_d) w_cnt++;
                else begin
                    bus.WREADY = 1'b1;
                    cap_wdata  = bus.WDATA;
                    cap_wstrb  = bus.WSTRB;
                end
            end
        end
    end

    initial begin
        bus.BVALID = 1'b0;
        bus.BRESP  = 1'b0;
        b_cnt = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn || bus.BVALID) begin
                bus.BVALID = 1'b0;
                bus.BRESP  = 1'b0;
                b_cnt = 0;
            end else if (bus.BREADY) begin
                if (b_cnt < b_d) b_cnt++;
                else begin
                    bus.BVALID = 1'b1;
                    bus.BRESP  = cfg_bresp;
                end
            end
        end
    end

    initial begin
        bus.ARREADY = 1'b0;
        ar_cnt = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn || bus.ARREADY) begin
                bus.ARREADY = 1'b0;
                ar_cnt = 0;
            end else if (bus.ARVALID) begin
                if (ar_cnt < ar_d) ar_cnt++;
                else begin
                    bus.ARREADY = 1'b1;
                    cap_araddr  = bus.ARADDR;
                end
            end
        end
    end

    initial begin
        bus.RVALID = 1'b0;
        bus.RRESP  = 1'b0;
        bus.RDATA  = 32'hBAD0_BAD0;
        r_cnt = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn || bus.RVALID) begin
                bus.RVALID = 1'b0;
                bus.RRESP  = 1'b0;
                bus.RDATA  = 32'hBAD0_BAD0;
                r_cnt = 0;
            end else if (bus.RREADY) begin
                if (r_cnt < r_d) r_cnt++;
                else begin
                    bus.RVALID = 1'b1;
                    bus.RRESP  = cfg_rresp;
                    bus.RDATA  = cfg_rdata;
                end
            end
        end
    end

    // ---------------- monitor: payload stability, VALID persistence, history -
    initial forever begin
        @(negedge ACLK);
        #1;
        if (ARESETn) begin
            if (p_aw_pend && (bus.AWVALID !== 1'b1 || bus.AWADDR !== p_awaddr)) proto_err++;
            if (p_w_pend && (bus.WVALID !== 1'b1 || bus.WDATA !== p_wdata ||
                             bus.WSTRB !== p_wstrb)) proto_err++;
            if (p_ar_pend && (bus.ARVALID !== 1'b1 || bus.ARADDR !== p_araddr)) proto_err++;
            if (in_txn) begin
                mon_rel = cyc - t_acc;
                if (mon_rel >= 0 && mon_rel < 64) begin
                    awv_hist[mon_rel]  = bus.AWVALID;
                    wv_hist[mon_rel]   = bus.WVALID;
                    arv_hist[mon_rel]  = bus.ARVALID;
                    brdy_hist[mon_rel] = bus.BREADY;
                end
            end
        end
        p_aw_pend = ARESETn && bus.AWVALID && !bus.AWREADY;
        p_w_pend  = ARESETn && bus.WVALID  && !bus.WREADY;
        p_ar_pend = ARESETn && bus.ARVALID && !bus.ARREADY;
        p_awaddr  = bus.AWADDR;
        p_wdata   = bus.WDATA;
        p_wstrb   = bus.WSTRB;
        p_araddr  = bus.ARADDR;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge ACLK);
        #1;
    endtask

    // Issue one command and follow it to its completion pulse. Returns at the
    // sample point of the rsp_valid cycle. 'keep' leaves cmd_valid asserted.
    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit keep, output int waits);
        int n;
        int cr_bad;
        int exp_lat;
        for (int i = 0; i < 64; i++) begin
            awv_hist[i] = 1'b0; wv_hist[i] = 1'b0; arv_hist[i] = 1'b0; brdy_hist[i] = 1'b0;
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        waits = 0;
        do begin
            step();
            waits++;
        end while (cmd_ready !== 1'b1 && waits < 50);
        check("accept_timeout", 64'(cmd_ready), 64'd1);
        t_acc  = cyc;
        in_txn = 1'b1;
        step();
        if (!keep) cmd_valid = 1'b0;
        check("cycle1_valids", {61'd0, bus.AWVALID, bus.WVALID, bus.ARVALID},
              wr ? 64'b110 : 64'b001);
        cr_bad = 0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 80) begin
            if (cmd_ready !== 1'b0) cr_bad++;
            step();
            n++;
        end
        if (cmd_ready !== 1'b0) cr_bad++;
        check("rsp_timeout", 64'(rsp_valid), 64'd1);
        exp_lat = wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;
        check("latency", 64'(cyc - t_acc), 64'(exp_lat));
        check("rsp_write", 64'(rsp_write), 64'(wr));
        check("rsp_rdata", 64'(rsp_rdata), wr ? 64'd0 : 64'(cfg_rdata));
        check("rsp_resp", 64'(rsp_resp), wr ? 64'(cfg_bresp) : 64'(cfg_rresp));
        check("bus_addr", wr ? 64'(cap_awaddr) : 64'(cap_araddr), 64'(a));
        if (wr) begin
            check("bus_wdata", 64'(cap_wdata), 64'(d));
            check("bus_wstrb", 64'(cap_wstrb), 64'(s));
        end
        check("cmd_ready_busy", 64'(cr_bad), 64'd0);
    endtask

    task automatic after_rsp();
        step();
        in_txn = 1'b0;
        check("single_pulse", 64'(rsp_valid), 64'd0);
        check("idle_ready", 64'(cmd_ready), 64'd1);
    endtask

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        aw_d = aw; w_d = w; b_d = b; ar_d = ar; r_d = r;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int waits;
        int n;
        int stray;
        logic        wr;
        logic [31:0] a, d;
        logic [3:0]  s;

        set_delays(0, 0, 0, 0, 0);
        cfg_bresp = 1'(RESP_OKAY);
        cfg_rresp = 1'(RESP_OKAY);
        cfg_rdata = 32'h0;
        ARESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;

        // Reset state
        step();
        step();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_bus_ctrl", {59'd0, bus.AWVALID, bus.WVALID, bus.BREADY,
                               bus.ARVALID, bus.RREADY}, 64'd0);
        check("rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, 64'd0);
        check("rst_addr", 64'(bus.AWADDR), 64'd0);
        ARESETn = 1'b1;
        #1;
        check("ready_before_edge", 64'(cmd_ready), 64'd0);
        step();
        check("ready_first_edge", 64'(cmd_ready), 64'd1);

        // Basic write, all immediate
        do_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, waits);
        after_rsp();

        // Read with ARREADY after 2 waits and RDATA after 3 waits
        set_delays(0, 0, 0, 2, 3);
        cfg_rdata = 32'h1234_5678;
        do_cmd(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, waits);
        check("arvalid_held", {61'd0, arv_hist[1], arv_hist[2], arv_hist[3]}, 64'b111);
        check("arvalid_drop", 64'(arv_hist[4]), 64'd0);
        after_rsp();

        // WREADY four cycles ahead of AWREADY
        set_delays(4, 0, 0, 0, 0);
        do_cmd(1'b1, 32'h44, 32'hA5A5_0F0F, 4'h5, 1'b0, waits);
        check("w_cycle1", 64'(wv_hist[1]), 64'd1);
        check("w_drop", 64'(wv_hist[2]), 64'd0);
        check("aw_hold", {62'd0, awv_hist[2], awv_hist[5]}, 64'b11);
        check("aw_drop", 64'(awv_hist[6]), 64'd0);
        check("bready_pre_aw", 64'(brdy_hist[5]), 64'd0);
        check("bready_post_aw", 64'(brdy_hist[6]), 64'd1);
        after_rsp();

        // Error response is passed through
        set_delays(1, 2, 1, 0, 0);
        cfg_bresp = 1'b1;
        do_cmd(1'b1, 32'h80, 32'h0BAD_F00D, 4'h3, 1'b0, waits);
        after_rsp();
        cfg_bresp = 1'(RESP_OKAY);

        // cmd_valid held high across back-to-back commands
        set_delays(0, 1, 0, 1, 0);
        cfg_rdata = 32'hCAFE_0001;
        do_cmd(1'b1, 32'h100, 32'h1111_2222, 4'hC, 1'b1, waits);
        do_cmd(1'b0, 32'h104, 32'h0, 4'h0, 1'b1, waits);
        check("b2b_accept_wait", 64'(waits), 64'd1);
        cmd_write = 1'b1;
        cmd_wdata = 32'h3333_4444;
        cmd_addr  = 32'h108;
        cmd_wstrb = 4'hF;
        do_cmd(1'b1, 32'h108, 32'h3333_4444, 4'hF, 1'b0, waits);
        check("b2b_accept_wait2", 64'(waits), 64'd1);
        after_rsp();

        // Randomized traffic
        for (int t = 0; t < 12; t++) begin
            wr = 1'($urandom_range(0, 1));
            a  = $urandom & 32'hFFFF_FFFC;
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            set_delays(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)));
            cfg_bresp = 1'($urandom_range(0, 1));
            cfg_rresp = 1'($urandom_range(0, 1));
            cfg_rdata = $urandom;
            do_cmd(wr, a, d, s, 1'b0, waits);
            after_rsp();
        end

        // Reset while the read is waiting in RD_DATA
        set_delays(0, 0, 0, 0, 10);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h200;
        n = 0;
        do begin step(); n++; end while (cmd_ready !== 1'b1 && n < 50);
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (bus.RREADY !== 1'b1 && n < 20) begin step(); n++; end
        check("rd_data_reached", 64'(bus.RREADY), 64'd1);
        #2;
        ARESETn = 1'b0;
        #1;
        check("async_drop", {57'd0, bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID,
                             bus.RREADY, cmd_ready, rsp_valid}, 64'd0);
        stray = 0;
        step();
        if (rsp_valid !== 1'b0) stray++;
        step();
        ARESETn = 1'b1;
        #1;
        check("rel_ready_before_edge", 64'(cmd_ready), 64'd0);
        step();
        check("rel_ready_first_edge", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid !== 1'b0) stray++;
            step();
        end
        check("no_rsp_after_reset", 64'(stray), 64'd0);

        // Recovery transaction
        set_delays(0, 0, 0, 0, 0);
        cfg_rresp = 1'(RESP_OKAY);
        cfg_rdata = 32'h5A5A_A5A5;
        do_cmd(1'b0, 32'h300, 32'h0, 4'h0, 1'b0, waits);
        after_rsp();

        check("protocol_violations", 64'(proto_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
